// File: rtl/ctrl_hazard_stage.sv
// ctrl_hazard_stage: ID/EX control-bundle register with programmable bubble
// insertion, stall/flush handling and a valid/ready handshake to decode.
// Optional build macro: CTRL_HAZARD_STATS_EN adds a saturating 16-bit
// count of bubble cycles written to ctrl_out (port stat_bubbles).
//
// state  | meaning
// PASS   | ctrl_in is registered each unstalled cycle, or a bubble run starts
// BUBBLE | remaining bubbles of a multi-cycle run are being inserted
module ctrl_hazard_stage #(
  parameter int                CTRL_W      = 13,
  parameter logic [CTRL_W-1:0] BUBBLE_VAL  = {CTRL_W{1'b0}},
  parameter int                MAX_BUBBLES = 3,
  parameter int                CNT_W       = $clog2(MAX_BUBBLES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              stall,
  input  logic              flush,
  input  logic              bubble_req,
  input  logic [CNT_W-1:0]  bubble_cnt,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              out_valid,
  output logic [CNT_W-1:0]  bubbles_left,
  output logic              busy
`ifdef CTRL_HAZARD_STATS_EN
  ,
  output logic [15:0]       stat_bubbles
`endif
);

  typedef enum logic {PASS = 1'b0, BUBBLE = 1'b1} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BUBBLES);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] eff_cnt;
  logic             take_bubble;

  // Saturate oversize requests and decide whether a run starts this cycle.
  always_comb begin
    eff_cnt     = (bubble_cnt > MAX_CNT) ? MAX_CNT : bubble_cnt;
    take_bubble = (state == PASS) && bubble_req && (eff_cnt != '0);
    in_ready    = (state == PASS) && !stall && !flush && !take_bubble;
    busy        = (state == BUBBLE);
  end

  // Pipeline register and bubble sequencer; priority reset > flush > stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= PASS;
      ctrl_out     <= BUBBLE_VAL;
      out_valid    <= 1'b0;
      bubbles_left <= '0;
    end else if (flush) begin
      state        <= PASS;
      ctrl_out     <= BUBBLE_VAL;
      out_valid    <= 1'b0;
      bubbles_left <= '0;
    end else if (!stall) begin
      case (state)
        PASS: begin
          if (take_bubble) begin
            ctrl_out     <= BUBBLE_VAL;
            out_valid    <= 1'b0;
            bubbles_left <= eff_cnt - ONE_CNT;
            state        <= (eff_cnt > ONE_CNT) ? BUBBLE : PASS;
          end else begin
            ctrl_out     <= ctrl_in;
            out_valid    <= in_valid;
          end
        end
        BUBBLE: begin
          // bubbles_left is at least 1 whenever BUBBLE is entered.
          ctrl_out     <= BUBBLE_VAL;
          out_valid    <= 1'b0;
          bubbles_left <= bubbles_left - ONE_CNT;
          if (bubbles_left == ONE_CNT) state <= PASS;
        end
        default: state <= PASS;
      endcase
    end
  end

`ifdef CTRL_HAZARD_STATS_EN
  logic bubble_write;

  assign bubble_write = !flush && !stall && (take_bubble || (state == BUBBLE));

  // Saturating count of bubble cycles actually written to ctrl_out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_bubbles <= 16'h0000;
    end else if (bubble_write && (stat_bubbles != 16'hFFFF)) begin
      stat_bubbles <= stat_bubbles + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_hazard_stage.sv
// Directed bench for ctrl_hazard_stage with a scoreboard queue: the driver
// pushes hand-computed post-edge outputs, a monitor pops and compares them.
module tb_ctrl_hazard_stage;

  localparam int CTRL_W = 13;
  localparam int CNT_W  = 3;

  typedef struct {
    int               step;
    logic [CTRL_W-1:0] ctrl;
    logic             v;
    logic [CNT_W-1:0] left;
    logic             busy;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [CTRL_W-1:0] ctrl_in;
  logic              in_valid;
  logic              in_ready;
  logic              stall;
  logic              flush;
  logic              bubble_req;
  logic [CNT_W-1:0]  bubble_cnt;
  logic [CTRL_W-1:0] ctrl_out;
  logic              out_valid;
  logic [CNT_W-1:0]  bubbles_left;
  logic              busy;
`ifdef CTRL_HAZARD_STATS_EN
  logic [15:0]       stat_bubbles;
`endif

  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;
  exp_t exp_q[$];

  ctrl_hazard_stage #(
    .CTRL_W(CTRL_W),
    .BUBBLE_VAL({CTRL_W{1'b0}}),
    .MAX_BUBBLES(3),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ctrl_in(ctrl_in),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .stall(stall),
    .flush(flush),
    .bubble_req(bubble_req),
    .bubble_cnt(bubble_cnt),
    .ctrl_out(ctrl_out),
    .out_valid(out_valid),
    .bubbles_left(bubbles_left),
    .busy(busy)
`ifdef CTRL_HAZARD_STATS_EN
    ,
    .stat_bubbles(stat_bubbles)
`endif
  );

  always #5 clk = ~clk;

  // Monitor: after each rising edge, compare the registered outputs.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (ctrl_out !== e.ctrl || out_valid !== e.v ||
          bubbles_left !== e.left || busy !== e.busy) begin
        errors++;
        $display("FAIL step%0d outputs: got ctrl=%h v=%b left=%0d busy=%b, want ctrl=%h v=%b left=%0d busy=%b",
                 e.step, ctrl_out, out_valid, bubbles_left, busy,
                 e.ctrl, e.v, e.left, e.busy);
      end
    end
  end

  // Drive one cycle of inputs, check combinational in_ready (-1 skips),
  // and queue the outputs expected after the coming edge.
  task automatic step(input logic r, input logic [CTRL_W-1:0] ci, input logic iv,
                      input logic st, input logic fl, input logic br,
                      input logic [CNT_W-1:0] bc, input int exp_ready,
                      input logic [CTRL_W-1:0] e_ctrl, input logic e_v,
                      input logic [CNT_W-1:0] e_left, input logic e_busy);
    exp_t e;
    step_no++;
    rst_n = r; ctrl_in = ci; in_valid = iv; stall = st; flush = fl;
    bubble_req = br; bubble_cnt = bc;
    #1;
    if (exp_ready >= 0) begin
      checks++;
      if (in_ready !== exp_ready[0]) begin
        errors++;
        $display("FAIL step%0d in_ready: got %b want %0d", step_no, in_ready, exp_ready);
      end
    end
    e.step = step_no; e.ctrl = e_ctrl; e.v = e_v; e.left = e_left; e.busy = e_busy;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; ctrl_in = '0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    bubble_req = 1'b0; bubble_cnt = '0;
    @(negedge clk);
    //    rst  ctrl_in   iv st fl br bc  rdy  ctrl_out  v  left busy
    step(0, 13'h0000, 0, 0, 0, 0, 0, -1, 13'h0000, 0, 0, 0);
    step(0, 13'h0000, 0, 0, 0, 0, 0, -1, 13'h0000, 0, 0, 0);
    step(1, 13'h0A5B, 1, 0, 0, 0, 0,  1, 13'h0A5B, 1, 0, 0);
    // bubble run of 2
    step(1, 13'h1234, 1, 0, 0, 1, 2,  0, 13'h0000, 0, 1, 1);
    step(1, 13'h1234, 1, 0, 0, 0, 0,  0, 13'h0000, 0, 0, 0);
    step(1, 13'h1234, 1, 0, 0, 0, 0,  1, 13'h1234, 1, 0, 0);
    // saturation: 7 -> 3
    step(1, 13'h0555, 1, 0, 0, 1, 7,  0, 13'h0000, 0, 2, 1);
    step(1, 13'h0555, 1, 0, 0, 0, 0,  0, 13'h0000, 0, 1, 1);
    step(1, 13'h0555, 1, 0, 0, 0, 0,  0, 13'h0000, 0, 0, 0);
    step(1, 13'h0555, 1, 0, 0, 0, 0,  1, 13'h0555, 1, 0, 0);
    // stall mid-bubble at bubbles_left=1, bubble_req during stall ignored
    step(1, 13'h0777, 1, 0, 0, 1, 3,  0, 13'h0000, 0, 2, 1);
    step(1, 13'h0777, 1, 0, 0, 0, 0,  0, 13'h0000, 0, 1, 1);
    step(1, 13'h0777, 1, 1, 0, 0, 0,  0, 13'h0000, 0, 1, 1);
    step(1, 13'h0777, 1, 1, 0, 1, 3,  0, 13'h0000, 0, 1, 1);
    step(1, 13'h0777, 1, 0, 0, 0, 0,  0, 13'h0000, 0, 0, 0);
    step(1, 13'h0777, 1, 0, 0, 0, 0,  1, 13'h0777, 1, 0, 0);
    // stall holds a valid bundle, then flush beats stall and bubble_req
    step(1, 13'h0FFF, 1, 0, 0, 0, 0,  1, 13'h0FFF, 1, 0, 0);
    step(1, 13'h0123, 1, 1, 0, 0, 0,  0, 13'h0FFF, 1, 0, 0);
    step(1, 13'h0123, 1, 1, 1, 1, 3,  0, 13'h0000, 0, 0, 0);
    // bubble_cnt=0 is a normal load; in_valid=0 still loads ctrl_in
    step(1, 13'h0ABC, 1, 0, 0, 1, 0,  1, 13'h0ABC, 1, 0, 0);
    step(1, 13'h1FFF, 0, 0, 0, 0, 0,  1, 13'h1FFF, 0, 0, 0);
    // reset mid-run
    step(1, 13'h0100, 1, 0, 0, 1, 3,  0, 13'h0000, 0, 2, 1);
    step(0, 13'h0100, 1, 0, 0, 0, 0, -1, 13'h0000, 0, 0, 0);
    step(1, 13'h0100, 1, 0, 0, 0, 0,  1, 13'h0100, 1, 0, 0);
    // flush mid-run
    step(1, 13'h0200, 1, 0, 0, 1, 3,  0, 13'h0000, 0, 2, 1);
    step(1, 13'h0200, 1, 0, 1, 0, 0,  0, 13'h0000, 0, 0, 0);
    step(1, 13'h0200, 1, 0, 0, 0, 0,  1, 13'h0200, 1, 0, 0);
    // single bubble stays in PASS
    step(1, 13'h0300, 1, 0, 0, 1, 1,  0, 13'h0000, 0, 0, 0);
    step(1, 13'h0300, 1, 0, 0, 0, 0,  1, 13'h0300, 1, 0, 0);
    // bubble_req ignored while in BUBBLE
    step(1, 13'h0400, 1, 0, 0, 1, 2,  0, 13'h0000, 0, 1, 1);
    step(1, 13'h0400, 1, 0, 0, 1, 3,  0, 13'h0000, 0, 0, 0);
    step(1, 13'h0400, 1, 0, 0, 0, 0,  1, 13'h0400, 1, 0, 0);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries want 0", exp_q.size());
    end
`ifdef CTRL_HAZARD_STATS_EN
    // Since the mid-run reset: 1 (flushed run) + 1 + 2 bubbles written.
    checks++;
    if (stat_bubbles !== 16'd4) begin
      errors++;
      $display("FAIL stat_bubbles: got %0d want 4", stat_bubbles);
    end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ctrl_hazard_stage.md
Name: ctrl_hazard_stage

Overview:
- Parametrised successor to the decode-stage control-zeroing mux.
- Registers the control-unit bundle into the ID/EX boundary.
- Inserts a programmable run of bubble cycles, where the control bundle is forced to a safe NOP value, on a hazard request.
- Honours pipeline stall (hold) and flush (kill), and drives a valid/ready pair so upstream fetch/decode knows when to advance.

Parameters:
- CTRL_W, 13: width of the packed control bundle (am 2, rf_en 1, alu_op 4, load 1, branch_link 1, s_bit 1, rw 1, size 1, datamem_en 1).
- BUBBLE_VAL, {CTRL_W{1'b0}}: value driven on ctrl_out during a bubble or after a flush.
- MAX_BUBBLES, 3: largest bubble run accepted per request.
- CNT_W, $clog2(MAX_BUBBLES+1): width of the bubble count fields.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; synchronous, active-low.
- ctrl_in  in  CTRL_W  control bundle from the control unit.
- in_valid  in  1  ctrl_in holds a real instruction.
- in_ready  out  1  stage accepts ctrl_in this cycle.
- stall  in  1  hold the registered bundle and freeze the bubble counter.
- flush  in  1  kill the registered bundle and cancel pending bubbles.
- bubble_req  in  1  hazard detected; insert bubbles.
- bubble_cnt  in  CNT_W  number of bubbles requested (0 means none).
- ctrl_out  out  CTRL_W  registered control bundle to EX.
- out_valid  out  1  ctrl_out is a real instruction (0 during bubble or after flush).
- bubbles_left  out  CNT_W  bubbles still to be inserted after the current cycle.
- busy  out  1  high when state is BUBBLE.

Behaviour:
- Reset: on rst_n=0 at a clk edge, the stage sets:
  - ctrl_out=BUBBLE_VAL, out_valid=0, bubbles_left=0, state=PASS.
  - Clock and reset are fixed: one clock, clk; reset rst_n is synchronous and active-low, sampled only on the rising edge of clk.
- States are PASS and BUBBLE. busy = (state==BUBBLE).
- in_ready is combinational: in_ready = (state==PASS) && !stall && !flush && !(bubble_req && eff_cnt!=0).
- eff_cnt = min(bubble_cnt, MAX_BUBBLES). Requests above MAX_BUBBLES saturate; they do not wrap.
- Per-edge priority: reset > flush > stall > bubble > load.
- flush:
  - Sets ctrl_out=BUBBLE_VAL, out_valid=0, bubbles_left=0, state=PASS.
  - Discards ctrl_in this cycle.
  - Overrides a simultaneous stall or bubble_req.
- stall (no flush):
  - ctrl_out, out_valid, bubbles_left and state all hold.
  - A bubble_req raised in the same cycle is ignored; the hazard unit re-asserts it.
- PASS with bubble_req and eff_cnt=N>0:
  - Sets ctrl_out=BUBBLE_VAL, out_valid=0, bubbles_left=N-1.
  - state becomes BUBBLE if N>1, otherwise stays PASS.
  - ctrl_in is not consumed; upstream holds it.
- PASS with bubble_req and eff_cnt=0: treated as no request; normal load.
- PASS, normal load: ctrl_out<=ctrl_in and out_valid<=in_valid. When in_valid=0, ctrl_out still loads ctrl_in but out_valid=0.
- BUBBLE:
  - Each unstalled cycle drives BUBBLE_VAL with out_valid=0 and decrements bubbles_left.
  - When bubbles_left reaches 0 in that update, state returns to PASS.
  - bubble_req is ignored while in BUBBLE; bubbles do not accumulate.
- Resulting timing:
  - Total bubbles seen at ctrl_out equals eff_cnt, barring stall or flush.
  - The held instruction appears one cycle after the last bubble.
- Latency: one cycle from ctrl_in to ctrl_out.
- Reset asserted mid-bubble-run: run abandoned, state returns to PASS next edge.

Optional Feature:
- Macro: CTRL_HAZARD_STATS_EN.
- When defined, adds output stat_bubbles (16 bits):
  - Counts every cycle in which a bubble is written to ctrl_out; flush cycles are not counted.
  - Saturates at 16'hFFFF.
  - Cleared by reset.
- When undefined: port absent, no counter logic, all other behaviour identical.

Test Plan:
- Reset then pass-through: hold rst_n=0 for 2 cycles, release, drive ctrl_in=13'h0A5B with in_valid=1 → next cycle ctrl_out=13'h0A5B, out_valid=1, in_ready=1.
- Bubble run: bubble_req=1, bubble_cnt=2, ctrl_in=13'h1234 held → ctrl_out=0 with out_valid=0 for 2 cycles, busy=1 during the second, then 13'h1234 with out_valid=1; in_ready=0 for those 2 cycles.
- Saturation: bubble_cnt=7 with MAX_BUBBLES=3 → exactly 3 bubble cycles; bubbles_left sequence 2,1,0.
- Stall mid-bubble: after a bubble_cnt=3 request, assert stall for 2 cycles at bubbles_left=1 → bubbles_left holds at 1, ctrl_out holds 0, run completes after stall drops; 3 bubble cycles total.
- Flush priority: stall=1, flush=1, bubble_req=1 in the same cycle while ctrl_out=13'h0FFF → next cycle ctrl_out=0, out_valid=0, state PASS, bubbles_left=0.
- With CTRL_HAZARD_STATS_EN: two bubble_cnt=3 requests and one flush → stat_bubbles=6.
